// File: rtl/tea_iter_core.sv
// Iterative TEA en/decryption core: one TEA cycle (two Feistel rounds) per enabled clock edge.
// Optional registered header comparator on decrypt results, built when TEA_HDR_CHECK_EN is defined.
module tea_iter_core #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E37_79B9
`ifdef TEA_HDR_CHECK_EN
  ,
  parameter logic [63:0] HEADER = 64'h2550_4446_2D31_2E35
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         encrypt,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block
`ifdef TEA_HDR_CHECK_EN
  ,
  output logic         hdr_match
`endif
);

  localparam int unsigned     CntW       = $clog2(ROUNDS + 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(ROUNDS - 1);
  localparam logic [31:0]     SumDecInit = DELTA * 32'(ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     sum_q, sum_d;
  logic [31:0]     v0_q, v0_d;
  logic [31:0]     v1_q, v1_d;
  logic [127:0]    key_q, key_d;
  logic            enc_q, enc_d;
  logic [63:0]     out_block_q, out_block_d;
  logic            out_valid_q, out_valid_d;

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] enc_v0, enc_v1, dec_v0, dec_v1;
  logic [31:0] rnd_v0, rnd_v1, rnd_sum;
  logic        accept;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // Gated by rst so the engine never advertises readiness while held in reset.
  assign in_ready  = rst & ena & (state_q == StIdle);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

  always_comb begin
    enc_v0  = v0_q + tea_f(v1_q, sum_q, k0, k1);
    enc_v1  = v1_q + tea_f(enc_v0, sum_q, k2, k3);
    dec_v1  = v1_q - tea_f(v0_q, sum_q, k2, k3);
    dec_v0  = v0_q - tea_f(dec_v1, sum_q, k0, k1);
    rnd_v0  = enc_q ? enc_v0 : dec_v0;
    rnd_v1  = enc_q ? enc_v1 : dec_v1;
    rnd_sum = enc_q ? (sum_q + DELTA) : (sum_q - DELTA);
  end

`ifdef TEA_HDR_CHECK_EN
  logic hdr_match_q, hdr_match_d;
  assign hdr_match = hdr_match_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    key_d       = key_q;
    enc_d       = enc_q;
    out_block_d = out_block_q;
    out_valid_d = out_valid_q;
`ifdef TEA_HDR_CHECK_EN
    hdr_match_d = hdr_match_q;
`endif
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            v0_d    = in_block[63:32];
            v1_d    = in_block[31:0];
            key_d   = key;
            enc_d   = encrypt;
            sum_d   = encrypt ? DELTA : SumDecInit;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          v0_d  = rnd_v0;
          v1_d  = rnd_v1;
          sum_d = rnd_sum;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            out_block_d = {rnd_v0, rnd_v1};
            out_valid_d = 1'b1;
`ifdef TEA_HDR_CHECK_EN
            hdr_match_d = !enc_q && ({rnd_v0, rnd_v1} == HEADER);
`endif
            state_d     = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
`ifdef TEA_HDR_CHECK_EN
            hdr_match_d = 1'b0;
`endif
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sum_q       <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      key_q       <= '0;
      enc_q       <= 1'b0;
      out_block_q <= '0;
      out_valid_q <= 1'b0;
`ifdef TEA_HDR_CHECK_EN
      hdr_match_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      key_q       <= key_d;
      enc_q       <= enc_d;
      out_block_q <= out_block_d;
      out_valid_q <= out_valid_d;
`ifdef TEA_HDR_CHECK_EN
      hdr_match_q <= hdr_match_d;
`endif
    end
  end

endmodule

// File: tb/tb_tea_iter_core.sv
// Self-checking bench for tea_iter_core: three instances (ROUNDS = 32, 1, 64) and a scoreboard
// fed by a behavioural TEA model.
module tb_tea_iter_core;

  localparam int          NDut   = 3;
  localparam logic [31:0] DELTA  = 32'h9E37_79B9;
  localparam logic [63:0] HEADER = 64'h2550_4446_2D31_2E35;
  localparam logic [127:0] Key2  = 128'h48756C6B_20697320_7468616C_616D6963;

  typedef struct {
    logic [63:0] blk;
    logic        hdr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         ena;
  logic         encrypt   [NDut];
  logic         in_valid  [NDut];
  logic         in_ready  [NDut];
  logic         out_valid [NDut];
  logic         out_ready [NDut];
  logic [63:0]  in_block  [NDut];
  logic [63:0]  out_block [NDut];
  logic [127:0] key       [NDut];
`ifdef TEA_HDR_CHECK_EN
  logic         hdr_match [NDut];
`endif

  exp_t        sb[$];
  logic [63:0] last_blk;
  int          errors = 0;
  int          checks = 0;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    tea_iter_core #(
      .ROUNDS(g == 0 ? 32 : (g == 1 ? 1 : 64)),
      .DELTA (DELTA)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .encrypt  (encrypt[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_block (in_block[g]),
      .key      (key[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_block(out_block[g])
`ifdef TEA_HDR_CHECK_EN
      ,
      .hdr_match(hdr_match[g])
`endif
    );
  end

  function automatic int unsigned rounds_of(input int d);
    return (d == 0) ? 32 : ((d == 1) ? 1 : 64);
  endfunction

  function automatic logic [31:0] tf(input logic [31:0] x, input logic [31:0] s,
                                     input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  function automatic logic [63:0] tea_model(input logic [63:0] blk, input logic [127:0] k,
                                            input logic enc, input int unsigned rounds);
    logic [31:0] v0, v1, sum;
    v0  = blk[63:32];
    v1  = blk[31:0];
    sum = enc ? DELTA : DELTA * rounds;
    for (int unsigned i = 0; i < rounds; i++) begin
      if (enc) begin
        v0  = v0 + tf(v1, sum, k[127:96], k[95:64]);
        v1  = v1 + tf(v0, sum, k[63:32], k[31:0]);
        sum = sum + DELTA;
      end else begin
        v1  = v1 - tf(v0, sum, k[63:32], k[31:0]);
        v0  = v0 - tf(v1, sum, k[127:96], k[95:64]);
        sum = sum - DELTA;
      end
    end
    return {v0, v1};
  endfunction

  function automatic exp_t make_exp(input logic [63:0] blk, input logic [127:0] k,
                                    input logic enc, input int d);
    exp_t e;
    e.blk = tea_model(blk, k, enc, rounds_of(d));
    e.hdr = !enc && (e.blk == HEADER);
    return e;
  endfunction

  // Offer a block and wait (bounded) for the accept edge; ends at the negedge after it.
  task automatic start_block(input int d, input logic [63:0] blk, input logic [127:0] k,
                             input logic enc, output int waits);
    waits = 0;
    @(negedge clk);
    in_block[d] = blk;
    key[d]      = k;
    encrypt[d]  = enc;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (!in_ready[d]) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b required 1", d, in_ready[d]);
      in_valid[d] = 1'b0;
      return;
    end
    sb.push_back(make_exp(blk, k, enc, d));
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_block[d] = {$urandom, $urandom};
    key[d]      = {$urandom, $urandom, $urandom, $urandom};
    encrypt[d]  = ~enc;
  endtask

  // Wait for out_valid counting edges since accept; optionally randomise ena meanwhile.
  task automatic finish_block(input int d, input string name, input bit toggle, input bit ack);
    int   lat   = 0;
    int   zeros = 0;
    exp_t e;
    while (lat < 400) begin
      if (toggle) begin
        ena = 1'($urandom_range(0, 1));
        if (!ena) zeros++;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid[d]) break;
    end
    ena = 1'b1;
    checks++;
    if (!out_valid[d]) begin
      errors++;
      $display("FAIL %s_timeout dut%0d: out_valid=%b required 1", name, d, out_valid[d]);
      return;
    end
    checks++;
    if (lat != int'(rounds_of(d)) + zeros) begin
      errors++;
      $display("FAIL %s_latency dut%0d: got %0d required %0d", name, d, lat,
               int'(rounds_of(d)) + zeros);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard dut%0d: got output, required no output", name, d);
      return;
    end
    e        = sb.pop_front();
    last_blk = e.blk;
    checks++;
    if (out_block[d] !== e.blk) begin
      errors++;
      $display("FAIL %s_block dut%0d: got %h required %h", name, d, out_block[d], e.blk);
    end
`ifdef TEA_HDR_CHECK_EN
    checks++;
    if (hdr_match[d] !== e.hdr) begin
      errors++;
      $display("FAIL %s_hdr dut%0d: got %b required %b", name, d, hdr_match[d], e.hdr);
    end
`endif
    if (ack) begin
      out_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[d] = 1'b0;
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s_ack dut%0d: out_valid=%b in_ready=%b required 0/1", name, d,
                 out_valid[d], in_ready[d]);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDut; d++) begin
      checks++;
      if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || out_block[d] !== 64'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: rdy=%b vld=%b blk=%h required 0/0/0", d,
                 in_ready[d], out_valid[d], out_block[d]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready[0]);
    end
  endtask

  task automatic test_zero_key();
    int w;
    start_block(0, 64'h0, 128'h0, 1'b1, w);
    finish_block(0, "zero_key", 1'b0, 1'b0);
    checks++;
    if (out_block[0] !== 64'h41EA3A0A_94BAA940) begin
      errors++;
      $display("FAIL zero_key_vector: got %h required 41ea3a0a94baa940", out_block[0]);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_encrypt();
    int w;
    start_block(0, HEADER, Key2, 1'b1, w);
    finish_block(0, "encrypt", 1'b0, 1'b1);
  endtask

  task automatic test_decrypt();
    int          w;
    logic [63:0] ct;
    ct = tea_model(HEADER, Key2, 1'b1, 32);
    start_block(0, ct, Key2, 1'b0, w);
    finish_block(0, "decrypt", 1'b0, 1'b0);
    checks++;
    if (out_block[0] !== HEADER) begin
      errors++;
      $display("FAIL decrypt_header: got %h required %h", out_block[0], HEADER);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    start_block(0, ct, Key2 ^ 128'h1, 1'b0, w);
    finish_block(0, "decrypt_badkey", 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int          w;
    logic [63:0] blk_a;
    start_block(0, 64'h0123_4567_89AB_CDEF, Key2, 1'b1, w);
    finish_block(0, "bp_first", 1'b0, 1'b0);
    blk_a = last_blk;
    in_block[0] = 64'hFEDC_BA98_7654_3210;
    key[0]      = Key2;
    encrypt[0]  = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_block[0] !== blk_a || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle%0d: blk=%h rdy=%b vld=%b required %h/0/1", i,
                 out_block[0], in_ready[0], out_valid[0], blk_a);
      end
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b required 1/0", in_ready[0], out_valid[0]);
    end
    sb.push_back(make_exp(64'hFEDC_BA98_7654_3210, Key2, 1'b1, 0));
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    finish_block(0, "bp_second", 1'b0, 1'b1);
  endtask

  task automatic test_ena();
    int w;
    start_block(0, 64'h1111_2222_3333_4444, Key2, 1'b1, w);
    finish_block(0, "ena_toggle", 1'b1, 1'b1);
    start_block(0, 64'h5555_6666_7777_8888, Key2, 1'b0, w);
    finish_block(0, "ena_toggle_dec", 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    int   w;
    exp_t dropped;
    start_block(0, 64'hDEAD_BEEF_CAFE_F00D, Key2, 1'b1, w);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_reset: vld=%b rdy=%b required 0/0", out_valid[0], in_ready[0]);
    end
    if (sb.size() != 0) dropped = sb.pop_front();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_release: vld=%b rdy=%b required 0/1", out_valid[0], in_ready[0]);
    end
    start_block(0, 64'hDEAD_BEEF_CAFE_F00D, Key2, 1'b1, w);
    finish_block(0, "abort_next", 1'b0, 1'b1);
  endtask

  task automatic test_rounds();
    int          w;
    logic [63:0] ct;
    for (int d = 1; d < NDut; d++) begin
      start_block(d, 64'h0, 128'h0, 1'b1, w);
      finish_block(d, "rounds_zero", 1'b0, 1'b1);
      ct = tea_model(HEADER, Key2, 1'b1, rounds_of(d));
      start_block(d, ct, Key2, 1'b0, w);
      finish_block(d, "rounds_dec", 1'b0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int   n      = 0;
    int   seen   = 0;
    int   first  = 0;
    int   second = 0;
    exp_t e;
    sb.push_back(make_exp(64'hA5A5_5A5A_0F0F_F0F0, Key2, 1'b1, 0));
    sb.push_back(make_exp(64'hA5A5_5A5A_0F0F_F0F0, Key2, 1'b1, 0));
    @(negedge clk);
    in_block[0]  = 64'hA5A5_5A5A_0F0F_F0F0;
    key[0]       = Key2;
    encrypt[0]   = 1'b1;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    while (n < 200 && seen < 2) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid[0]) begin
        seen++;
        if (seen == 1) first = n;
        else begin
          second = n;
          in_valid[0] = 1'b0;
        end
        e = sb.pop_front();
        checks++;
        if (out_block[0] !== e.blk) begin
          errors++;
          $display("FAIL b2b_block%0d: got %h required %h", seen, out_block[0], e.blk);
        end
      end
    end
    in_valid[0] = 1'b0;
    checks++;
    if (seen != 2 || (second - first) != 34) begin
      errors++;
      $display("FAIL b2b_period: outputs=%0d period=%0d required 2/34", seen, second - first);
    end
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: vld=%b pending=%0d required 0/0", out_valid[0], sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    for (int d = 0; d < NDut; d++) begin
      encrypt[d]   = 1'b0;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      in_block[d]  = 64'h0;
      key[d]       = 128'h0;
    end
    test_reset();
    test_zero_key();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_ena();
    test_abort();
    test_rounds();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
